// File: rtl/fir_decim_out.sv
// fir_decim_out
// Decimates the FIR filter output stream, rounds and scales each kept sample,
// saturates it to the output width and queues it in a small first-word
// fall-through FIFO for the consumer.
//
// Ports
//   clk         single clock, rising edge
//   n_rst       asynchronous active-low reset
//   en          enable for decimation and capture
//   dec_n       decimation ratio (0 treated as 1)
//   din         FIR output, one new sample every clk
//   dout        FIFO head sample
//   dout_valid  FIFO non-empty
//   dout_ready  consumer accept; pop when dout_valid && dout_ready
//   sat_pulse   one-cycle pulse when a written sample was saturated
//   ovf         sticky: a sample was dropped because the FIFO was full
//   ovf_clr     synchronous clear for ovf
//   fifo_cnt    current FIFO occupancy
//
// Capture-to-dout_valid latency is 3 clk: capture reg, round/shift reg,
// saturate reg, then the FIFO write. DEPTH must be a power of 2, >= 2.
module fir_decim_out #(
    parameter int IN_W  = 30,
    parameter int OUT_W = 16,
    parameter int SHIFT = 12,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          en,
    input  logic [7:0]                    dec_n,
    input  logic signed [IN_W-1:0]        din,
    output logic signed [OUT_W-1:0]       dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          sat_pulse,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic [$clog2(DEPTH):0]        fifo_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic signed [IN_W:0] HALF    = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Decimation phase. dec_q only reloads at a period boundary (or while
    // disabled) so a ratio change never alters the period in progress.
    logic [7:0] cnt;
    logic [7:0] dec_q;
    logic [7:0] dec_eff;
    logic       capture;

    assign dec_eff = (dec_n == 8'd0) ? 8'd1 : dec_n;
    assign capture = en && (cnt == 8'd0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt   <= 8'd0;
            dec_q <= 8'd1;
        end else if (!en) begin
            cnt   <= 8'd0;
            dec_q <= dec_eff;
        end else if (cnt == dec_q - 8'd1) begin
            cnt   <= 8'd0;
            dec_q <= dec_eff;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Pipeline: capture -> round/shift -> saturate.
    // The rounding add is done one bit wider so it cannot overflow.
    logic signed [IN_W-1:0]  s0;
    logic signed [IN_W:0]    s1;
    logic signed [OUT_W-1:0] s2;
    logic                    v0, v1, v2, sat2;
    logic signed [IN_W:0]    rnd_sum;

    assign rnd_sum = (IN_W+1)'(s0) + HALF;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s0   <= '0;
            s1   <= '0;
            s2   <= '0;
            v0   <= 1'b0;
            v1   <= 1'b0;
            v2   <= 1'b0;
            sat2 <= 1'b0;
        end else begin
            v0 <= capture;
            if (capture)
                s0 <= din;
            v1 <= v0;
            s1 <= rnd_sum >>> SHIFT;
            v2 <= v1;
            if (s1 > SAT_MAX) begin
                s2   <= SAT_MAX[OUT_W-1:0];
                sat2 <= 1'b1;
            end else if (s1 < SAT_MIN) begin
                s2   <= SAT_MIN[OUT_W-1:0];
                sat2 <= 1'b1;
            end else begin
                s2   <= s1[OUT_W-1:0];
                sat2 <= 1'b0;
            end
        end
    end

    // Output FIFO. dout is a register holding the head so it only moves on
    // a pop or on a write into an empty FIFO.
    logic signed [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic                    full, pop, push, drop;

    assign dout_valid = (fifo_cnt != '0);
    assign full       = (fifo_cnt == (AW+1)'(DEPTH));
    assign pop        = dout_valid && dout_ready;
    assign push       = v2 && (!full || pop);
    assign drop       = v2 && full && !pop;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s2;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            dout      <= '0;
            sat_pulse <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase

            if (push && !dout_valid) begin
                dout <= s2;
            end else if (pop) begin
                // Next head is the stored entry behind the current one, or the
                // sample being written if the current head is the only one.
                if (fifo_cnt > (AW+1)'(1))
                    dout <= mem[rd_ptr + AW'(1)];
                else if (push)
                    dout <= s2;
            end

            sat_pulse <= push && sat2;

            if (drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_decim_out.sv
module tb_fir_decim_out;

    localparam int IN_W  = 30;
    localparam int OUT_W = 16;
    localparam int SHIFT = 12;
    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     n_rst, en, dout_ready, ovf_clr;
    logic [7:0]               dec_n;
    logic signed [IN_W-1:0]   din;
    logic signed [OUT_W-1:0]  dout;
    logic                     dout_valid, sat_pulse, ovf;
    logic [$clog2(DEPTH):0]   fifo_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_decim_out #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (en),
        .dec_n      (dec_n),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_pulse  (sat_pulse),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .fifo_cnt   (fifo_cnt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference arithmetic: round half up, shift, clamp to output range.
    function automatic longint model_out(input longint d, output bit s);
        longint r;
        longint hi;
        longint lo;
        r  = (d + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end else if (r < lo) begin
            r = lo;
            s = 1'b1;
        end
        return r;
    endfunction

    typedef struct {
        int     val;
        bit     sat;
        longint due;
    } item_t;

    item_t  pq[$];      // samples in flight, with the edge at which they reach the FIFO
    int     fq[$];      // expected FIFO contents, head first
    int     got[$];     // values the DUT handed to the consumer
    int     ph = 0;
    int     ratio = 1;
    bit     m_ovf = 0;
    bit     m_sat = 0;
    longint cyc = 0;
    int     sat_seen = 0;
    bit     last_valid = 0;
    int     last_dout = 0;

    always @(posedge clk) begin
        bit     pop, acc, has_w, s;
        longint v;
        if (!n_rst) begin
            pq.delete();
            fq.delete();
            ph = 0;
            ratio = 1;
            m_ovf = 0;
            m_sat = 0;
        end else begin
            if (last_valid && dout_ready)
                got.push_back(last_dout);
            pop   = (fq.size() > 0) && dout_ready;
            has_w = (pq.size() > 0) && (pq[0].due == cyc);
            acc   = has_w && ((fq.size() < DEPTH) || pop);
            m_sat = acc && pq[0].sat;
            if (has_w && !acc)
                m_ovf = 1;
            else if (ovf_clr)
                m_ovf = 0;
            if (pop)
                void'(fq.pop_front());
            if (acc)
                fq.push_back(pq[0].val);
            if (has_w)
                void'(pq.pop_front());
            if (en && ph == 0) begin
                v = model_out(longint'(din), s);
                pq.push_back('{val: int'(v), sat: s, due: cyc + 3});
            end
            if (!en || ph == ratio - 1) begin
                ph = 0;
                ratio = (dec_n == 8'd0) ? 1 : int'(dec_n);
            end else begin
                ph++;
            end
        end
        cyc++;
        #1;
        chk("dout_valid", longint'(dout_valid), longint'(fq.size() != 0));
        chk("fifo_cnt", longint'(fifo_cnt), longint'(fq.size()));
        chk("ovf", longint'(ovf), longint'(m_ovf));
        chk("sat_pulse", longint'(sat_pulse), longint'(m_sat));
        if (fq.size() != 0)
            chk("dout", longint'(dout), longint'(fq[0]));
        else if (!n_rst)
            chk("dout_rst", longint'(dout), 0);
        if (sat_pulse)
            sat_seen++;
        last_valid = dout_valid;
        last_dout  = int'(dout);
    end

    task automatic idle(input int n);
        en = 1'b0;
        dout_ready = 1'b1;
        ovf_clr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_got(input string nm, input int e[$]);
        chk({nm, "_len"}, longint'(got.size()), longint'(e.size()));
        for (int i = 0; i < e.size() && i < got.size(); i++)
            chk(nm, longint'(got[i]), longint'(e[i]));
    endtask

    initial begin
        int  exp_q[$];
        bit  s;
        bit  hit;
        int  sat0;

        n_rst = 1'b0;
        en = 1'b0;
        dec_n = 8'd1;
        din = '0;
        dout_ready = 1'b1;
        ovf_clr = 1'b0;

        // Hand-computed values pinning the reference arithmetic.
        chk("pin_409600", model_out(409600, s), 100);
        chk("pin_2048", model_out(2048, s), 1);
        chk("pin_m2048", model_out(-2048, s), 0);
        chk("pin_m2049", model_out(-2049, s), -1);
        chk("pin_satpos", model_out(536870911, s), 32767);
        chk("pin_satpos_flag", longint'(s), 1);
        chk("pin_satneg", model_out(-536870912, s), -32768);

        repeat (3) @(negedge clk);
        chk("rst_dout", longint'(dout), 0);
        chk("rst_valid", longint'(dout_valid), 0);
        chk("rst_cnt", longint'(fifo_cnt), 0);
        chk("rst_ovf", longint'(ovf), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // Rounding and latency.
        got.delete();
        en = 1'b1; din = IN_W'(409600);
        @(negedge clk); din = IN_W'(2048);
        chk("lat_e0", longint'(dout_valid), 0);
        @(negedge clk); din = -IN_W'(2048);
        chk("lat_e1", longint'(dout_valid), 0);
        @(negedge clk); din = -IN_W'(2049);
        chk("lat_e2", longint'(dout_valid), 0);
        @(negedge clk); en = 1'b0;
        chk("lat_e3", longint'(dout_valid), 1);
        idle(6);
        exp_q = '{100, 1, 0, -1};
        check_got("round", exp_q);

        // Saturation.
        got.delete();
        sat0 = sat_seen;
        en = 1'b1; din = {1'b0, {(IN_W - 1){1'b1}}};
        @(negedge clk); din = {1'b1, {(IN_W - 1){1'b0}}};
        @(negedge clk);
        idle(6);
        exp_q = '{32767, -32768};
        check_got("sat", exp_q);
        chk("sat_pulses", longint'(sat_seen - sat0), 2);

        // Decimation with ratio changes mid-period and ratio 0.
        dec_n = 8'd4;
        @(negedge clk);
        got.delete();
        for (int k = 0; k < 17; k++) begin
            dec_n = (k < 5) ? 8'd4 : (k < 13) ? 8'd2 : 8'd0;
            din = IN_W'(k * 4096);
            en = 1'b1;
            @(negedge clk);
        end
        idle(6);
        exp_q = '{0, 4, 8, 10, 12, 14, 15, 16};
        check_got("decim", exp_q);

        // Backpressure, overflow, drain, clear.
        got.delete();
        dout_ready = 1'b0;
        dec_n = 8'd1;
        for (int k = 1; k <= 6; k++) begin
            en = 1'b1;
            din = IN_W'(k * 4096);
            @(negedge clk);
        end
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("bp_cnt", longint'(fifo_cnt), 4);
        chk("bp_ovf", longint'(ovf), 1);
        chk("bp_head", longint'(dout), 1);
        dout_ready = 1'b1;
        repeat (6) @(negedge clk);
        exp_q = '{1, 2, 3, 4};
        check_got("drain", exp_q);
        chk("ovf_held", longint'(ovf), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", longint'(ovf), 0);

        // Simultaneous push and pop while full.
        dout_ready = 1'b0;
        en = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            din = IN_W'((k + 1) * 4096);
            @(negedge clk);
            if (fifo_cnt == 3'd4)
                hit = 1'b1;
        end
        chk("full_reached", longint'(hit), 1);
        dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = IN_W'((k + 40) * 4096);
            @(negedge clk);
            chk("full_pp_cnt", longint'(fifo_cnt), 4);
            chk("full_pp_ovf", longint'(ovf), 0);
        end
        idle(8);

        // Reset with 2 samples in flight and 3 queued.
        dout_ready = 1'b0;
        dec_n = 8'd1;
        for (int k = 0; k < 5; k++) begin
            en = 1'b1;
            din = IN_W'((k + 7) * 4096);
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        chk("mid_cnt", longint'(fifo_cnt), 3);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_dout", longint'(dout), 0);
        chk("mid_rst_valid", longint'(dout_valid), 0);
        chk("mid_rst_cnt", longint'(fifo_cnt), 0);
        chk("mid_rst_sat", longint'(sat_pulse), 0);
        chk("mid_rst_ovf", longint'(ovf), 0);
        @(negedge clk);
        n_rst = 1'b1;
        dout_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_stale", longint'(dout_valid), 0);
        end

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0)
                dec_n = 8'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1)
                din = IN_W'($urandom);
            else
                din = IN_W'(int'($urandom_range(0, 1048576)) - 524288);
            dout_ready = ($urandom_range(0, 9) < 7);
            ovf_clr = ($urandom_range(0, 19) == 0);
            @(negedge clk);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
